// File: rtl/ce_rate_avg_pkg.sv
// Shared definitions for the PID-path decimators: FSM encoding, ratio limits, accumulator sizing.
// Build option CE_RATE_AVG_ROUND_EN selects round-half-up and adds one accumulator guard bit.
package ce_rate_avg_pkg;

    typedef enum logic {
        ALIGN = 1'b0,
        RUN   = 1'b1
    } avg_state_t;

    localparam int RATIO_LOG2_MIN = 1;
    localparam int RATIO_LOG2_MAX = 8;

`ifdef CE_RATE_AVG_ROUND_EN
    localparam int ROUND_GUARD = 1;
`else
    localparam int ROUND_GUARD = 0;
`endif

    // Width that holds the sum of 2^ratio_log2 full-scale samples without overflow.
    function automatic int acc_width(input int data_width, input int ratio_log2);
        return data_width + ratio_log2;
    endfunction

endpackage

// File: rtl/ce_rate_acc.sv
// Window accumulator: running sum, sample count and overrun flag, plus the final average.
// With CE_RATE_AVG_ROUND_EN the sum is biased by half an LSB of the result before the shift.
module ce_rate_acc
    import ce_rate_avg_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int RATIO_LOG2 = 2,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, RATIO_LOG2) + ROUND_GUARD
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         sys_ce,
    input  logic                         sample_en,
    input  logic                         restart,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic signed [DATA_WIDTH-1:0] avg_data,
    output logic                         window_bad
);

    localparam int                    CNT_W   = RATIO_LOG2 + 1;
    localparam logic [CNT_W-1:0]      WIN_LEN = CNT_W'(2 ** RATIO_LOG2);

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_final;
    logic signed [ACC_WIDTH-1:0] sum_adj;
    logic [CNT_W-1:0]            count;
    logic [CNT_W-1:0]            count_final;
    logic                        overrun;
    logic                        overrun_final;
    logic                        take;

    // "final" values include a sample arriving in the same cycle as the window close.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc_final     = acc;
        count_final   = count;
        take          = sample_en & (count != WIN_LEN);
        if (take) begin
            acc_final   = acc + ACC_WIDTH'(in_data);
            count_final = count + 1'b1;
        end
        overrun_final = overrun | (sample_en & (count == WIN_LEN));
        window_bad    = overrun_final | (count_final != WIN_LEN);
    end

`ifdef CE_RATE_AVG_ROUND_EN
    localparam logic signed [ACC_WIDTH-1:0] ROUND_BIAS = ACC_WIDTH'(2 ** (RATIO_LOG2 - 1));
    assign sum_adj = acc_final + ROUND_BIAS;
`else
    assign sum_adj = acc_final;
`endif

    assign avg_data = DATA_WIDTH'(sum_adj >>> RATIO_LOG2);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc     <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else if (sys_ce) begin
            if (restart) begin
                acc     <= '0;
                count   <= '0;
                overrun <= 1'b0;
            end else begin
                acc     <= acc_final;
                count   <= count_final;
                overrun <= overrun_final;
            end
        end
    end

endmodule

// File: rtl/ce_rate_avg.sv
// Decimating averager between the fast clock enable and the slow PID loop rate.
// Build option CE_RATE_AVG_ROUND_EN: round half up instead of truncating toward minus infinity.
module ce_rate_avg
    import ce_rate_avg_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int RATIO_LOG2 = 2,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, RATIO_LOG2)
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         sys_ce,
    input  logic                         slow_ce,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    output logic                         window_err,
    input  logic                         err_clr
);

    if (RATIO_LOG2 < RATIO_LOG2_MIN || RATIO_LOG2 > RATIO_LOG2_MAX) begin : g_bad_ratio
        $error("ce_rate_avg: RATIO_LOG2 out of range");
    end

    avg_state_t                  state;
    avg_state_t                  state_next;
    logic                        restart;
    logic                        close;
    logic                        sample_en;
    logic                        window_bad;
    logic signed [DATA_WIDTH-1:0] avg_data;

    assign restart   = sys_ce & slow_ce;
    assign close     = restart & (state == RUN);
    assign sample_en = sys_ce & in_valid & (state == RUN);

    ce_rate_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .RATIO_LOG2 (RATIO_LOG2),
        .ACC_WIDTH  (ACC_WIDTH + ROUND_GUARD)
    ) u_acc (
        .clk        (clk),
        .resetn     (resetn),
        .sys_ce     (sys_ce),
        .sample_en  (sample_en),
        .restart    (restart),
        .in_data    (in_data),
        .avg_data   (avg_data),
        .window_bad (window_bad)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ALIGN;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ALIGN:   if (restart) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = ALIGN;
        endcase
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            window_err <= 1'b0;
        end else begin
            out_valid <= close;
            if (close) out_data <= avg_data;
            if (close && window_bad)   window_err <= 1'b1;
            else if (sys_ce && err_clr) window_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ce_rate_avg.sv
// Self-checking bench for ce_rate_avg: directed vector table, corner sequences, randomized model compare.
module tb_ce_rate_avg;

    localparam int DW = 16;
    localparam int RL2 = 2;
    localparam int N = 4;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic                 sys_ce = 1'b0;
    logic                 slow_ce = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 err_clr = 1'b0;
    logic signed [DW-1:0] out_data;
    logic                 out_valid;
    logic                 window_err;

    int n_checks = 0;
    int n_fail = 0;

    ce_rate_avg #(.DATA_WIDTH(DW), .RATIO_LOG2(RL2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .sys_ce     (sys_ce),
        .slow_ce    (slow_ce),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .window_err (window_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    // Reference model: the list of samples kept for the open window and a count of offered samples.
    bit m_run;
    int m_win[$];
    int m_att;
    int m_d;
    bit m_v;
    bit m_e;

    function automatic int floor_div(input int s, input int d);
        int q;
        q = s / d;
        if ((s % d != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int ref_avg(input int s);
`ifdef CE_RATE_AVG_ROUND_EN
        return floor_div(s + N / 2, N);
`else
        return floor_div(s, N);
`endif
    endfunction

    task automatic model_reset();
        m_run = 1'b0;
        m_win.delete();
        m_att = 0;
        m_d = 0;
        m_v = 1'b0;
        m_e = 1'b0;
    endtask

    task automatic model_step(input bit ce, input bit slow, input bit valid, input int data, input bit clr);
        bit bad;
        int sum;
        bad = 1'b0;
        m_v = 1'b0;
        if (ce) begin
            if (m_run) begin
                if (valid) begin
                    m_att++;
                    if (m_win.size() < N) m_win.push_back(data);
                end
                if (slow) begin
                    sum = 0;
                    foreach (m_win[k]) sum += m_win[k];
                    m_d = ref_avg(sum);
                    m_v = 1'b1;
                    bad = (m_att != N);
                    m_win.delete();
                    m_att = 0;
                end
            end else if (slow) begin
                m_run = 1'b1;
                m_win.delete();
                m_att = 0;
            end
            if (bad) m_e = 1'b1;
            else if (clr) m_e = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic expect_out(input string name, input int d, input bit v, input bit e);
        check({name, "_data"}, $signed(out_data), d);
        check({name, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        check({name, "_err"}, {31'd0, window_err}, {31'd0, e});
    endtask

    // Drive one clock of inputs, then sample outputs 1 time unit after the edge.
    task automatic step(input bit ce, input bit slow, input bit valid, input int data, input bit clr);
        sys_ce = ce;
        slow_ce = slow;
        in_valid = valid;
        in_data = DW'(data);
        err_clr = clr;
        model_step(ce, slow, valid, data, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset_now(input string name);
        #2 resetn = 1'b0;
        model_reset();
        #1;
        expect_out(name, 0, 1'b0, 1'b0);
        sys_ce = 1'b0;
        slow_ce = 1'b0;
        in_valid = 1'b0;
        err_clr = 1'b0;
        @(posedge clk);
        #2 resetn = 1'b1;
    endtask

    typedef struct {
        bit ce;
        bit slow;
        bit valid;
        int data;
        bit clr;
        int exp_d;
        bit exp_v;
        bit exp_e;
    } vec_t;

    function automatic vec_t mk(input bit ce, input bit slow, input bit valid, input int data,
                                input bit clr, input int ed, input bit ev, input bit ee);
        vec_t r;
        r.ce = ce; r.slow = slow; r.valid = valid; r.data = data; r.clr = clr;
        r.exp_d = ed; r.exp_v = ev; r.exp_e = ee;
        return r;
    endfunction

    initial begin
        vec_t tbl[$];
        int neg_exp;
        int ce_cnt;
        int target;
        int r;
        bit ce;
        bit slow;
        bit valid;
        bit clr;
        int data;

`ifdef CE_RATE_AVG_ROUND_EN
        neg_exp = -1;
`else
        neg_exp = -2;
`endif
        // ALIGN, then windows: 10..40 (last coincident with slow_ce), negatives, full scale, plain.
        tbl.push_back(mk(1, 1, 0, 0,      0, 0,      0, 0));
        tbl.push_back(mk(1, 0, 1, 10,     0, 0,      0, 0));
        tbl.push_back(mk(1, 0, 1, 20,     0, 0,      0, 0));
        tbl.push_back(mk(1, 0, 1, 30,     0, 0,      0, 0));
        tbl.push_back(mk(1, 1, 1, 40,     0, 25,     1, 0));
        tbl.push_back(mk(0, 1, 1, 99,     0, 25,     0, 0));
        tbl.push_back(mk(1, 0, 1, -1,     0, 25,     0, 0));
        tbl.push_back(mk(1, 0, 1, -1,     0, 25,     0, 0));
        tbl.push_back(mk(1, 0, 1, -1,     0, 25,     0, 0));
        tbl.push_back(mk(1, 1, 1, -2,     0, neg_exp, 1, 0));
        tbl.push_back(mk(1, 0, 1, 32767,  0, neg_exp, 0, 0));
        tbl.push_back(mk(1, 0, 1, 32767,  0, neg_exp, 0, 0));
        tbl.push_back(mk(1, 0, 1, 32767,  0, neg_exp, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32767,  0, 32767,  1, 0));
        tbl.push_back(mk(1, 0, 1, -32768, 0, 32767,  0, 0));
        tbl.push_back(mk(1, 0, 1, -32768, 0, 32767,  0, 0));
        tbl.push_back(mk(1, 0, 1, -32768, 0, 32767,  0, 0));
        tbl.push_back(mk(1, 1, 1, -32768, 0, -32768, 1, 0));
        tbl.push_back(mk(1, 0, 1, 10,     0, -32768, 0, 0));
        tbl.push_back(mk(0, 0, 1, 77,     0, -32768, 0, 0));
        tbl.push_back(mk(1, 0, 1, 20,     0, -32768, 0, 0));
        tbl.push_back(mk(1, 0, 1, 30,     0, -32768, 0, 0));
        tbl.push_back(mk(1, 0, 1, 40,     0, -32768, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0,      0, 25,     1, 0));

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 0, 1'b0, 1'b0);
        #1 resetn = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].ce, tbl[i].slow, tbl[i].valid, tbl[i].data, tbl[i].clr);
            expect_out($sformatf("tbl%0d", i), tbl[i].exp_d, tbl[i].exp_v, tbl[i].exp_e);
        end

        // Short window: 3 samples, sum 24.
        step(1, 0, 1, 4, 0);
        step(1, 0, 1, 8, 0);
        step(1, 0, 1, 12, 0);
        step(1, 1, 0, 0, 0);
        expect_out("short", 6, 1'b1, 1'b1);
        // A good window does not clear the sticky flag.
        step(1, 0, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        step(1, 1, 1, 1, 0);
        expect_out("sticky", 1, 1'b1, 1'b1);
        step(1, 0, 0, 0, 1);
        expect_out("clr", 1, 1'b0, 1'b0);
        // Overrun: fifth sample dropped.
        repeat (4) step(1, 0, 1, 100, 0);
        step(1, 0, 1, 500, 0);
        step(1, 1, 0, 0, 0);
        expect_out("overrun", 100, 1'b1, 1'b1);
        step(1, 0, 0, 0, 1);
        check("clr2_err", {31'd0, window_err}, 0);
        // Error and err_clr in the same cycle: set wins.
        step(1, 0, 1, 8, 0);
        step(1, 0, 1, 8, 0);
        step(1, 1, 0, 0, 1);
        expect_out("setwins", 4, 1'b1, 1'b1);

        // Asynchronous reset while out_valid is high.
        async_reset_now("async_rst");
        step(1, 0, 1, 5, 0);
        step(1, 0, 1, 6, 0);
        step(1, 1, 0, 0, 0);
        expect_out("align_close", 0, 1'b0, 1'b0);
        step(1, 0, 1, 8, 0);
        step(1, 0, 1, 8, 0);
        step(1, 0, 1, 8, 0);
        step(1, 1, 1, 8, 0);
        expect_out("first_after_rst", 8, 1'b1, 1'b0);

        // Randomized traffic against the reference model.
        async_reset_now("rnd_rst");
        ce_cnt = 0;
        target = N;
        for (int c = 0; c < 3000; c++) begin
            ce = ($urandom_range(0, 3) != 0);
            slow = 1'b0;
            if (ce) begin
                ce_cnt++;
                if (ce_cnt >= target) begin
                    slow = 1'b1;
                    ce_cnt = 0;
                    r = $urandom_range(0, 9);
                    target = (r == 0) ? N - 1 : (r == 1) ? N + 1 : N;
                end
            end
            valid = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 19) == 0);
            r = $urandom_range(0, 15);
            data = (r == 0) ? 32767 : (r == 1) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
            step(ce, slow, valid, data, clr);
            check("rnd_data", $signed(out_data), m_d);
            check("rnd_valid", {31'd0, out_valid}, {31'd0, m_v});
            check("rnd_err", {31'd0, window_err}, {31'd0, m_e});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
